// File: rtl/cpu_bus_memory_if.sv
// cpu_bus_memory_if: CPU external bus between the cpu and its memory responder
interface cpu_bus_memory_if;
  logic [63:0] i_ad;
  logic [7:0]  i_tag;
  logic        i_astb;
  logic        i_rd;
  logic        i_wr;
  logic [63:0] o_data;
  logic [7:0]  o_tag;
  logic        o_err;
  logic [31:0] o_rcount;
  logic [31:0] o_wcount;
  modport master (
    output i_ad, i_tag, i_astb, i_rd, i_wr,
    input  o_data, o_tag, o_err, o_rcount, o_wcount
  );
  modport slave (
    input  i_ad, i_tag, i_astb, i_rd, i_wr,
    output o_data, o_tag, o_err, o_rcount, o_wcount
  );
endinterface

// File: rtl/cpu_bus_memory.sv
// cpu_bus_memory: word-addressed main-memory responder with protocol error flagging
module cpu_bus_memory #(
  parameter int AW    = 20,
  parameter int DEPTH = 65536
) (
  input logic clk,
  input logic reset,
  cpu_bus_memory_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, ADDR} state_t;
  logic [71:0]   mem [DEPTH];
  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n, ea;
  logic          viol, do_rd, do_wr, rd_in, wr_in, err_n;
  logic [63:0]   data_q;
  logic [7:0]    tag_q;
  logic          err_q;
  logic [31:0]   rcount_q, wcount_q;
  // Address latch: any strobe captures the address, only reset forgets it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
    end
  end
  // Next state, effective address and access/violation decode
  always_comb begin
    state_n = bus.i_astb ? ADDR : state;
    addr_n  = bus.i_astb ? bus.i_ad[AW-1:0] : addr;
    ea      = bus.i_astb ? bus.i_ad[AW-1:0] : addr;
    viol    = (bus.i_rd && bus.i_wr) || (bus.i_wr && bus.i_astb) ||
              ((bus.i_rd || bus.i_wr) && !bus.i_astb && state == IDLE);
    do_rd   = bus.i_rd && !bus.i_wr && (bus.i_astb || state == ADDR);
    do_wr   = bus.i_wr && !bus.i_rd && !bus.i_astb && state == ADDR;
    rd_in   = {1'b0, ea} < DEPTH_W;
    wr_in   = {1'b0, addr} < DEPTH_W;
    err_n   = viol || (do_rd && !rd_in) || (do_wr && !wr_in);
  end
  // Storage array: no reset so contents survive it, and a reset cycle cancels the write
  always_ff @(posedge clk) begin
    if (!reset && do_wr && wr_in) mem[addr[IW-1:0]] <= {bus.i_tag, bus.i_ad};
  end
  // Read data, error pulse and access counters
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      rcount_q <= '0;
      wcount_q <= '0;
    end else begin
      err_q <= err_n;
      if (do_rd) begin
        {tag_q, data_q} <= rd_in ? mem[ea[IW-1:0]] : 72'd0;
        rcount_q <= rcount_q + 32'd1;
      end
      if (do_wr && wr_in) wcount_q <= wcount_q + 32'd1;
    end
  end
  assign bus.o_data   = data_q;
  assign bus.o_tag    = tag_q;
  assign bus.o_err    = err_q;
  assign bus.o_rcount = rcount_q;
  assign bus.o_wcount = wcount_q;
endmodule

// File: tb/tb_cpu_bus_memory.sv
// tb_cpu_bus_memory: directed checks of the memory responder
module tb_cpu_bus_memory;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  cpu_bus_memory_if bus();
  cpu_bus_memory dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic astb, input logic rd, input logic wr, input logic [63:0] ad, input logic [7:0] tg);
    bus.i_astb = astb;
    bus.i_rd   = rd;
    bus.i_wr   = wr;
    bus.i_ad   = ad;
    bus.i_tag  = tg;
  endtask
  initial begin
    drive(0, 0, 0, 64'd0, 8'd0);
    dut.mem[5]    = {8'h3C, 64'h0123_4567_89AB_CDEF};
    dut.mem[7]    = {8'h77, 64'hDEAD_BEEF_0000_0007};
    dut.mem[9]    = {8'h11, 64'h0000_0000_0000_0099};
    dut.mem[32]   = {8'h22, 64'h0000_0000_0000_2222};
    step();
    step();
    reset = 1'b0;
    chk("rst_data", bus.o_data, 64'd0);
    chk("rst_tag", {56'd0, bus.o_tag}, 64'd0);
    chk("rst_err", {63'd0, bus.o_err}, 64'd0);
    chk("rst_rcount", {32'd0, bus.o_rcount}, 64'd0);
    chk("rst_wcount", {32'd0, bus.o_wcount}, 64'd0);
    drive(0, 1, 0, 64'd0, 8'd0);
    step();
    chk("idle_rd_err", {63'd0, bus.o_err}, 64'd1);
    chk("idle_rd_data", bus.o_data, 64'd0);
    chk("idle_rd_rcount", {32'd0, bus.o_rcount}, 64'd0);
    drive(0, 0, 0, 64'd0, 8'd0);
    step();
    chk("idle_err_clear", {63'd0, bus.o_err}, 64'd0);
    drive(1, 0, 1, 64'd9, 8'hAA);
    step();
    chk("astb_wr_err", {63'd0, bus.o_err}, 64'd1);
    chk("astb_wr_wcount", {32'd0, bus.o_wcount}, 64'd0);
    drive(0, 1, 0, 64'd0, 8'd0);
    step();
    chk("astb_wr_rd_data", bus.o_data, 64'h99);
    chk("astb_wr_rd_tag", {56'd0, bus.o_tag}, 64'h11);
    chk("astb_wr_rd_err", {63'd0, bus.o_err}, 64'd0);
    chk("astb_wr_rd_rcount", {32'd0, bus.o_rcount}, 64'd1);
    drive(1, 0, 0, 64'hFFFF_0000_0000_0005, 8'd0);
    step();
    drive(0, 1, 0, 64'd0, 8'd0);
    step();
    chk("rd5_data", bus.o_data, 64'h0123_4567_89AB_CDEF);
    chk("rd5_tag", {56'd0, bus.o_tag}, 64'h3C);
    chk("rd5_rcount", {32'd0, bus.o_rcount}, 64'd2);
    chk("rd5_err", {63'd0, bus.o_err}, 64'd0);
    drive(1, 0, 0, 64'h10, 8'd0);
    step();
    drive(0, 0, 1, 64'hFFFF_0000_FFFF_0000, 8'h81);
    step();
    chk("wr10_wcount", {32'd0, bus.o_wcount}, 64'd1);
    chk("wr10_data_held", bus.o_data, 64'h0123_4567_89AB_CDEF);
    chk("wr10_err", {63'd0, bus.o_err}, 64'd0);
    drive(0, 1, 0, 64'd0, 8'd0);
    step();
    chk("rd10_data", bus.o_data, 64'hFFFF_0000_FFFF_0000);
    chk("rd10_tag", {56'd0, bus.o_tag}, 64'h81);
    chk("rd10_rcount", {32'd0, bus.o_rcount}, 64'd3);
    drive(1, 0, 0, 64'h10000, 8'd0);
    step();
    chk("oor_astb_err", {63'd0, bus.o_err}, 64'd0);
    drive(0, 0, 1, 64'h1234, 8'h12);
    step();
    chk("oor_wr_err", {63'd0, bus.o_err}, 64'd1);
    chk("oor_wr_wcount", {32'd0, bus.o_wcount}, 64'd1);
    drive(0, 1, 0, 64'd0, 8'd0);
    step();
    chk("oor_rd_err", {63'd0, bus.o_err}, 64'd1);
    chk("oor_rd_data", bus.o_data, 64'd0);
    chk("oor_rd_tag", {56'd0, bus.o_tag}, 64'd0);
    chk("oor_rd_rcount", {32'd0, bus.o_rcount}, 64'd4);
    drive(0, 0, 0, 64'd0, 8'd0);
    step();
    chk("oor_err_clear", {63'd0, bus.o_err}, 64'd0);
    drive(1, 1, 0, 64'd7, 8'd0);
    step();
    chk("bypass_data", bus.o_data, 64'hDEAD_BEEF_0000_0007);
    chk("bypass_tag", {56'd0, bus.o_tag}, 64'h77);
    chk("bypass_err", {63'd0, bus.o_err}, 64'd0);
    chk("bypass_rcount", {32'd0, bus.o_rcount}, 64'd5);
    drive(0, 1, 1, 64'h5555, 8'h55);
    step();
    chk("rdwr_err", {63'd0, bus.o_err}, 64'd1);
    chk("rdwr_data_held", bus.o_data, 64'hDEAD_BEEF_0000_0007);
    chk("rdwr_rcount", {32'd0, bus.o_rcount}, 64'd5);
    chk("rdwr_wcount", {32'd0, bus.o_wcount}, 64'd1);
    drive(1, 0, 0, 64'h20, 8'd0);
    step();
    drive(0, 0, 1, 64'h55, 8'h55);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 64'd0, 8'd0);
    chk("midrst_data", bus.o_data, 64'd0);
    chk("midrst_tag", {56'd0, bus.o_tag}, 64'd0);
    chk("midrst_err", {63'd0, bus.o_err}, 64'd0);
    chk("midrst_rcount", {32'd0, bus.o_rcount}, 64'd0);
    chk("midrst_wcount", {32'd0, bus.o_wcount}, 64'd0);
    drive(0, 1, 0, 64'd0, 8'd0);
    step();
    chk("midrst_idle_err", {63'd0, bus.o_err}, 64'd1);
    chk("midrst_idle_rcount", {32'd0, bus.o_rcount}, 64'd0);
    drive(1, 1, 0, 64'h20, 8'd0);
    step();
    chk("midrst_nowrite_data", bus.o_data, 64'h2222);
    chk("midrst_nowrite_tag", {56'd0, bus.o_tag}, 64'h22);
    chk("midrst_kept_wcount", {32'd0, bus.o_wcount}, 64'd0);
    drive(1, 1, 0, 64'h10, 8'd0);
    step();
    chk("postrst_kept_data", bus.o_data, 64'hFFFF_0000_FFFF_0000);
    chk("postrst_rcount", {32'd0, bus.o_rcount}, 64'd2);
    drive(0, 0, 0, 64'd0, 8'd0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
